aes_192_sched: RTL
==================

Name: aes_192_sched

Overview:
- Two-requester scheduler and flow controller in front of the fully pipelined aes_192 core, which has no handshake.
- Arbitrates round-robin between two valid/ready request ports and drives the core's state and key inputs.
- Tracks in-flight operations with a LATENCY-deep tag pipeline and captures core results into a response FIFO.
- Returns each result on a valid/ready response port tagged with the requester id.
- Credit-based issue guarantees the FIFO never overflows under any response backpressure.

Parameters:
- LATENCY, 25: cycles from core inputs presented in cycle t to the matching core_out valid in cycle t+LATENCY; must match the core pipeline; ≥1.
- DEPTH, 4: response FIFO entries; power of two, ≥2; also the maximum number of outstanding operations.

Ports:
- clk  in  1  single clock, all state on rising edge
- nreset  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_state  in  128  requester 0 plaintext
- req0_key  in  192  requester 0 key
- req1_valid / req1_ready / req1_state / req1_key  as requester 0, for requester 1
- core_state  out  128  to aes_192 state input
- core_key  out  192  to aes_192 key input
- core_out  in  128  from aes_192 out
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accepts
- rsp_data  out  128  ciphertext
- rsp_id  out  1  originating requester
- busy  out  1  any operation in flight or buffered

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - All tag bits, FIFO pointers, inflight and fifo counters cleared.
  - Round-robin pointer favours requester 0.
  - Outputs: rsp_valid=0, busy=0, reqN_ready=0.
- Credit:
  - can_issue = (inflight_cnt + fifo_cnt) < DEPTH.
  - Any pop in the same cycle is ignored (conservative). Counters are clog2(DEPTH)+1 bits wide.
- Arbitration (combinational):
  - If can_issue and exactly one reqN_valid, grant N.
  - If both are valid, grant the requester favoured by the pointer.
  - reqN_ready = grant to N; at most one ready high per cycle.
  - reqN_ready may depend on reqN_valid. A requester holds its valid and data stable until it sees ready.
- Pointer: updates only on a grant, toward the non-granted requester. No grant means no change.
- Core drive:
  - core_state/core_key = the granted request's data, combinationally.
  - With no grant, both are driven to zero, so core power and toggling stay deterministic.
- Tag pipeline:
  - A LATENCY-stage shift register of {valid, id}.
  - Stage 0 loads {grant, granted id} at the edge ending the grant cycle; it shifts every cycle unconditionally.
  - The last stage is therefore valid in cycle t+LATENCY, aligned with core_out.
- Capture: when the last tag stage is valid, {core_out, id} is pushed into the FIFO at the end of that cycle. Core output in cycles with no valid tag is ignored.
- Counters:
  - inflight_cnt: +1 on grant, -1 on capture; simultaneous events net to zero.
  - fifo_cnt: +1 on push, -1 on pop (rsp_valid & rsp_ready); simultaneous push/pop nets to zero.
- Response port:
  - rsp_valid = fifo_cnt≠0; rsp_data/rsp_id come from the head entry.
  - Head data is stable while rsp_valid & !rsp_ready.
  - Order is strictly issue order.
- Latency: request accepted in cycle t → rsp_valid earliest in cycle t+LATENCY+1.
- Throughput: one issue per cycle when rsp_ready is held high and DEPTH ≥ LATENCY+1. Otherwise rate is limited to DEPTH per LATENCY+1 cycles.
- Boundaries:
  - FIFO full plus a capture is impossible; a simulation-only check flags it as an error.
  - Pointer wrap is natural (1 bit).
  - Reset mid-operation discards all in-flight and buffered results. Stale core pipeline contents are ignored because every tag is cleared.
- busy = (inflight_cnt≠0) | (fifo_cnt≠0).

Optional Feature:
- Macro: AES_SCHED_CNT_EN.
- Defined: adds outputs issue_cnt[31:0] and done_cnt[31:0].
  - issue_cnt increments on every grant; done_cnt increments on every response pop.
  - Both wrap modulo 2^32 and are cleared by nreset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single request: req0 state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da5, rsp_ready=1 → rsp_valid in cycle t+26 with rsp_data=f9fb29aefc384a250340d833b87ebc00, rsp_id=0; busy low afterwards.
- Back-to-back requests: req0 with the above, req1 in the next cycle with state=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f1011121314151617 → responses in consecutive cycles: f9fb29ae…/id0, then dda97ca4864cdfe06eaf70a0ec0d7191/id1.
- Contention: both valid continuously for 8 grants → grants alternate 0,1,0,1…; first grant goes to req0 after reset.
- Backpressure: rsp_ready=0, both requesters valid → exactly DEPTH=4 grants, then ready stays low. Raising rsp_ready → 4 responses in issue order, with issue resuming one grant per pop.
- Reset mid-flight: nreset pulsed low with 3 operations in flight → rsp_valid never asserts for them, busy=0; a new request afterwards completes correctly.
- With AES_SCHED_CNT_EN: after the above scenarios (no reset between), issue_cnt equals done_cnt.

Source files
------------

// File: rtl/aes_192_sched.sv
// Round-robin two-port scheduler and credit-based flow controller for a fully pipelined aes_192 core.
// Define AES_SCHED_CNT_EN to add the issue_cnt/done_cnt activity counters.
module aes_192_sched #(
  parameter int LATENCY = 25,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [191:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [191:0] req1_key,
  output logic [127:0] core_state,
  output logic [191:0] core_key,
  input  logic [127:0] core_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
`ifdef AES_SCHED_CNT_EN
  ,
  output logic [31:0]  issue_cnt,
  output logic [31:0]  done_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]      inflight_cnt_r;
  logic [CW-1:0]      fifo_cnt_r;
  logic [CW-1:0]      inflight_nxt_s;
  logic [CW-1:0]      fifo_nxt_s;
  logic [CW:0]        credit_s;
  logic               can_issue_s;
  logic               rr_ptr_r;
  logic               grant_s;
  logic               gnt_id_s;
  logic [LATENCY-1:0] tag_v_r;
  logic [LATENCY-1:0] tag_id_r;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic [127:0]       mem_data_r [DEPTH];
  logic               mem_id_r   [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic               rsp_valid_r;
  logic               busy_r;

  // Outstanding work is everything issued but not yet popped, so the FIFO can always absorb it.
  assign credit_s    = {1'b0, inflight_cnt_r} + {1'b0, fifo_cnt_r};
  assign can_issue_s = (credit_s < {1'b0, DEPTH_C});
  assign push_s      = tag_v_r[LATENCY-1];
  assign pop_s       = rsp_valid_r & rsp_ready;
  assign full_s      = (fifo_cnt_r == DEPTH_C);

  // Round-robin arbitration; nothing is granted while reset is asserted.
  always_comb begin
    grant_s  = 1'b0;
    gnt_id_s = 1'b0;
    if (nreset && can_issue_s) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          grant_s  = 1'b1;
          gnt_id_s = 1'b0;
        end
        2'b10: begin
          grant_s  = 1'b1;
          gnt_id_s = 1'b1;
        end
        2'b11: begin
          grant_s  = 1'b1;
          gnt_id_s = rr_ptr_r;
        end
        default: begin
          grant_s  = 1'b0;
          gnt_id_s = 1'b0;
        end
      endcase
    end else begin
      grant_s  = 1'b0;
      gnt_id_s = 1'b0;
    end
  end

  assign req0_ready = grant_s & ~gnt_id_s;
  assign req1_ready = grant_s & gnt_id_s;

  // Core input mux; idle cycles drive zeros to keep core toggling deterministic.
  always_comb begin
    core_state = 128'd0;
    core_key   = 192'd0;
    if (grant_s) begin
      if (gnt_id_s) begin
        core_state = req1_state;
        core_key   = req1_key;
      end else begin
        core_state = req0_state;
        core_key   = req0_key;
      end
    end else begin
      core_state = 128'd0;
      core_key   = 192'd0;
    end
  end

  // Next-state counters.
  always_comb begin
    inflight_nxt_s = inflight_cnt_r;
    fifo_nxt_s     = fifo_cnt_r;
    case ({grant_s, push_s})
      2'b10:   inflight_nxt_s = inflight_cnt_r + CW'(1);
      2'b01:   inflight_nxt_s = inflight_cnt_r - CW'(1);
      default: inflight_nxt_s = inflight_cnt_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   fifo_nxt_s = fifo_cnt_r + CW'(1);
      2'b01:   fifo_nxt_s = fifo_cnt_r - CW'(1);
      default: fifo_nxt_s = fifo_cnt_r;
    endcase
  end

  // Counters, arbitration pointer and registered status outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      inflight_cnt_r <= '0;
      fifo_cnt_r     <= '0;
      rr_ptr_r       <= 1'b0;
      rsp_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      inflight_cnt_r <= inflight_nxt_s;
      fifo_cnt_r     <= fifo_nxt_s;
      rsp_valid_r    <= (fifo_nxt_s != '0);
      busy_r         <= (inflight_nxt_s != '0) | (fifo_nxt_s != '0);
      if (grant_s) begin
        rr_ptr_r <= ~gnt_id_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Tag pipeline mirrors the core pipeline so the last stage lines up with core_out.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tag_v_r  <= '0;
      tag_id_r <= '0;
    end else begin
      tag_v_r[0]  <= grant_s;
      tag_id_r[0] <= gnt_id_s;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_r[i]  <= tag_v_r[i-1];
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // Response FIFO storage and write pointer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= 128'd0;
        mem_id_r[i]   <= 1'b0;
      end
      wr_ptr_r <= '0;
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= core_out;
      mem_id_r[wr_ptr_r]   <= tag_id_r[LATENCY-1];
      wr_ptr_r             <= wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // FIFO read pointer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr_r <= '0;
    end else if (pop_s) begin
      rd_ptr_r <= rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;
  assign rsp_data  = mem_data_r[rd_ptr_r];
  assign rsp_id    = mem_id_r[rd_ptr_r];

`ifdef AES_SCHED_CNT_EN
  logic [31:0] issue_cnt_r;
  logic [31:0] done_cnt_r;

  // Free-running activity counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      issue_cnt_r <= 32'd0;
      done_cnt_r  <= 32'd0;
    end else begin
      issue_cnt_r <= issue_cnt_r + {31'd0, grant_s};
      done_cnt_r  <= done_cnt_r + {31'd0, pop_s};
    end
  end

  assign issue_cnt = issue_cnt_r;
  assign done_cnt  = done_cnt_r;
`endif

  aes_192_sched_chk u_chk (
    .clk    (clk),
    .nreset (nreset),
    .push   (push_s),
    .full   (full_s),
    .rdy0   (req0_ready),
    .rdy1   (req1_ready)
  );

endmodule

// Simulation-only property checks for the scheduler.
module aes_192_sched_chk (
  input logic clk,
  input logic nreset,
  input logic push,
  input logic full,
  input logic rdy0,
  input logic rdy1
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!nreset) !(push && full))
    else $error("aes_192_sched: capture into a full response FIFO");

  a_one_ready: assert property (@(posedge clk) disable iff (!nreset) !(rdy0 && rdy1))
    else $error("aes_192_sched: both requesters granted");

endmodule
